// File: rtl/sd_block_writer_pkg.sv
// Shared constants and state encoding for the SD single-block (CMD24) writer.
package sd_block_writer_pkg;

    typedef enum logic [3:0] {
        IDLE, CMD, R1, TOKEN, DATA, CRC, DRESP, BUSYW, FINISH
    } state_t;

    localparam logic [7:0] CMD24        = 8'h58;
    localparam logic [7:0] DATA_TOKEN   = 8'hFE;
    localparam logic [7:0] FILL         = 8'hFF;
    localparam logic [7:0] DRESP_MASK   = 8'h1F;
    localparam logic [7:0] DRESP_ACCEPT = 8'h05;

    localparam logic [2:0] ERR_OK           = 3'd0;
    localparam logic [2:0] ERR_R1_TIMEOUT   = 3'd1;
    localparam logic [2:0] ERR_R1_REJECT    = 3'd2;
    localparam logic [2:0] ERR_DATA_REJECT  = 3'd3;
    localparam logic [2:0] ERR_BUSY_TIMEOUT = 3'd4;

    // Six-byte CMD24 frame: opcode, 32-bit address MSB first, dummy CRC byte.
    function automatic logic [7:0] cmd_byte(input logic [31:0] addr, input logic [2:0] idx);
        case (idx)
            3'd0:    cmd_byte = CMD24;
            3'd1:    cmd_byte = addr[31:24];
            3'd2:    cmd_byte = addr[23:16];
            3'd3:    cmd_byte = addr[15:8];
            3'd4:    cmd_byte = addr[7:0];
            default: cmd_byte = FILL;
        endcase
    endfunction

endpackage

// File: rtl/sd_block_writer.sv
// Writes one 512-byte block to an SD card in SPI mode through an external byte engine.
module sd_block_writer
    import sd_block_writer_pkg::*;
#(
    parameter int R1_POLL_MAX   = 8,
    parameter int BUSY_POLL_MAX = 65535
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        start,
    input  logic [31:0] block_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  spi_tx_data,
    output logic        spi_tx_start,
    input  logic [7:0]  spi_rx_data,
    input  logic        spi_done,
    output logic        spi_cs_n
);

    localparam int POLL_MAX = (R1_POLL_MAX > BUSY_POLL_MAX) ? R1_POLL_MAX : BUSY_POLL_MAX;
    localparam int PW       = $clog2(POLL_MAX + 1);

    state_t        state;
    logic          pend;
    logic [8:0]    cnt;
    logic [PW-1:0] poll;
    logic [31:0]   addr;
    logic [7:0]    tx_byte;
    logic          rx_ev;
    logic          can_issue;

    assign s_ready   = (state == DATA) && !pend;
    assign rx_ev     = pend && spi_done;
    assign can_issue = !pend && (state != IDLE) && (state != FINISH) && ((state != DATA) || s_valid);

    always_comb begin
        tx_byte = FILL;
        case (state)
            CMD:     tx_byte = cmd_byte(addr, cnt[2:0]);
            TOKEN:   tx_byte = DATA_TOKEN;
            DATA:    tx_byte = s_data;
            default: tx_byte = FILL;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state        <= IDLE;
            pend         <= 1'b0;
            cnt          <= '0;
            poll         <= '0;
            addr         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= ERR_OK;
            spi_tx_start <= 1'b0;
            spi_tx_data  <= FILL;
            spi_cs_n     <= 1'b1;
        end else begin
            spi_tx_start <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;

            // One byte in flight at a time; tx_data holds until its spi_done.
            if (can_issue) begin
                spi_tx_start <= 1'b1;
                spi_tx_data  <= tx_byte;
                pend         <= 1'b1;
            end
            if (rx_ev) pend <= 1'b0;

            case (state)
                IDLE: if (start) begin
                    state    <= CMD;
                    busy     <= 1'b1;
                    spi_cs_n <= 1'b0;
                    err_code <= ERR_OK;
                    addr     <= block_addr;
                    cnt      <= '0;
                    poll     <= '0;
                end
                CMD: if (rx_ev) begin
                    if (cnt == 9'd5) begin
                        state <= R1;
                        cnt   <= '0;
                    end else cnt <= cnt + 9'd1;
                end
                R1: if (rx_ev) begin
                    if (spi_rx_data == 8'h00) state <= TOKEN;
                    else if (spi_rx_data != FILL) begin
                        state <= IDLE; busy <= 1'b0; spi_cs_n <= 1'b1;
                        error <= 1'b1; err_code <= ERR_R1_REJECT;
                    end else if (poll == PW'(R1_POLL_MAX - 1)) begin
                        state <= IDLE; busy <= 1'b0; spi_cs_n <= 1'b1;
                        error <= 1'b1; err_code <= ERR_R1_TIMEOUT;
                    end else poll <= poll + PW'(1);
                end
                TOKEN: if (rx_ev) begin
                    state <= DATA;
                    cnt   <= '0;
                end
                DATA: if (rx_ev) begin
                    if (cnt == 9'd511) begin
                        state <= CRC;
                        cnt   <= '0;
                    end else cnt <= cnt + 9'd1;
                end
                CRC: if (rx_ev) begin
                    if (cnt == 9'd1) begin
                        state <= DRESP;
                        cnt   <= '0;
                    end else cnt <= cnt + 9'd1;
                end
                DRESP: if (rx_ev) begin
                    if ((spi_rx_data & DRESP_MASK) == DRESP_ACCEPT) begin
                        state <= BUSYW;
                        poll  <= '0;
                    end else begin
                        state <= IDLE; busy <= 1'b0; spi_cs_n <= 1'b1;
                        error <= 1'b1; err_code <= ERR_DATA_REJECT;
                    end
                end
                BUSYW: if (rx_ev) begin
                    // FINISH is the cycle in which done and the released chip select are seen.
                    if (spi_rx_data != 8'h00) begin
                        state <= FINISH; busy <= 1'b0; spi_cs_n <= 1'b1;
                        done  <= 1'b1;
                    end else if (poll == PW'(BUSY_POLL_MAX - 1)) begin
                        state <= IDLE; busy <= 1'b0; spi_cs_n <= 1'b1;
                        error <= 1'b1; err_code <= ERR_BUSY_TIMEOUT;
                    end else poll <= poll + PW'(1);
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
